// File: rtl/i2c_pkg.sv
// Shared types for the I2C single-master controller: FSM state,
// quarter-bit phase and the R/W bit values appended to the slave address.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        TXBIT,
        RXBIT,
        ACK_CHK,
        MACK,
        RSTART,
        STOP,
        FINISH
    } state_t;

    typedef enum logic [1:0] {
        Q0,
        Q1,
        Q2,
        Q3
    } quarter_t;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-bit tick generator: one-cycle tick every CLK_DIV clocks.
// Ports: clk, rst_n, hold (freeze and reload), clear (restart), tick.
module i2c_quarter_tick #(
    parameter int CLK_DIV = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold,
    input  logic clear,
    output logic tick
);

    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    logic [7:0] cnt;

    // A held quarter restarts from a full count once the hold drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RELOAD;
        end else if (clear || hold || cnt == 8'd0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 8'd1;
        end
    end

    assign tick = (cnt == 8'd0) && !hold;

endmodule

// File: rtl/i2c_controller.sv
// Single-master I2C controller: one register write or read per command.
// Ports: clk/rst_n, open-drain enables scl_oe/sda_oe, pad inputs
// scl_i/sda_i, command start/rd_wrn/slave_addr/sub_addr/wdata, status
// rdata/busy/done/nack. Define I2C_CTRL_STRETCH_EN for clock stretching.
module i2c_controller #(
    parameter int CLK_DIV = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_i,
    input  logic       sda_i,
    input  logic       start,
    input  logic       rd_wrn,
    input  logic [6:0] slave_addr,
    input  logic [7:0] sub_addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       nack
);

    import i2c_pkg::*;

    state_t     state, state_n;
    quarter_t   q;
    logic [2:0] bit_cnt;
    logic [1:0] byte_idx;
    logic [7:0] shreg;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] sub;
    logic [7:0] wbyte;
    logic       ack_s;
    logic       tick;
    logic       hold;
    logic       last;
    logic       accept;
    logic       active;
    logic       scl_low;

    assign active  = (state != IDLE) && (state != FINISH);
    assign accept  = start && !active;
    assign last    = tick && (q == Q3);
    assign scl_low = (q == Q0) || (q == Q1);
    assign busy    = active;
    assign done    = (state == FINISH);

`ifdef I2C_CTRL_STRETCH_EN
    logic [1:0] scl_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
        end
    end

    // SCL is released in every Q2; a low reading there is a stretch.
    assign hold = active && (q == Q2) && !scl_sync[1];
`else
    logic unused_scl;
    assign unused_scl = scl_i;
    assign hold = 1'b0;
`endif

    i2c_quarter_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .hold (hold),
        .clear(accept),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        scl_oe  = 1'b0;
        sda_oe  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_n = START;
            end
            START: begin
                sda_oe = (q == Q2) || (q == Q3);
                if (last) state_n = TXBIT;
            end
            RSTART: begin
                // SCL low in Q0 lets the peripheral drop its ACK
                // before SDA rises for the repeated start.
                scl_oe = (q == Q0);
                sda_oe = (q == Q2) || (q == Q3);
                if (last) state_n = TXBIT;
            end
            TXBIT: begin
                scl_oe = scl_low;
                sda_oe = ~shreg[7];
                if (last && bit_cnt == 3'd7) state_n = ACK_CHK;
            end
            ACK_CHK: begin
                scl_oe = scl_low;
                if (last) begin
                    if (ack_s) begin
                        state_n = STOP;
                    end else if (byte_idx == 2'd0) begin
                        state_n = TXBIT;
                    end else if (byte_idx == 2'd1) begin
                        state_n = rw ? RSTART : TXBIT;
                    end else begin
                        state_n = rw ? RXBIT : STOP;
                    end
                end
            end
            RXBIT: begin
                scl_oe = scl_low;
                if (last && bit_cnt == 3'd7) state_n = MACK;
            end
            MACK: begin
                scl_oe = scl_low;
                if (last) state_n = STOP;
            end
            STOP: begin
                scl_oe = (q == Q0);
                sda_oe = (q != Q3);
                if (last) state_n = FINISH;
            end
            FINISH: begin
                state_n = start ? START : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q        <= Q0;
            bit_cnt  <= 3'd0;
            byte_idx <= 2'd0;
            shreg    <= 8'd0;
            rw       <= RW_WRITE;
            addr     <= 7'd0;
            sub      <= 8'd0;
            wbyte    <= 8'd0;
            ack_s    <= 1'b1;
            rdata    <= 8'd0;
            nack     <= 1'b0;
        end else if (accept) begin
            q        <= Q0;
            bit_cnt  <= 3'd0;
            byte_idx <= 2'd0;
            shreg    <= {slave_addr, RW_WRITE};
            rw       <= rd_wrn;
            addr     <= slave_addr;
            sub      <= sub_addr;
            wbyte    <= wdata;
            nack     <= 1'b0;
        end else begin
            if (tick) q <= quarter_t'(q + 2'd1);
            if (tick && q == Q2) begin
                if (state == ACK_CHK) ack_s <= sda_i;
                if (state == RXBIT) shreg <= {shreg[6:0], sda_i};
            end
            if (last) begin
                case (state)
                    TXBIT: begin
                        shreg   <= {shreg[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    RXBIT: bit_cnt <= bit_cnt + 3'd1;
                    ACK_CHK: begin
                        if (ack_s) begin
                            nack <= 1'b1;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            if (byte_idx == 2'd0) begin
                                shreg <= sub;
                            end else if (byte_idx == 2'd1) begin
                                shreg <= rw ? {addr, RW_READ} : wbyte;
                            end
                        end
                    end
                    MACK: rdata <= shreg;
                    default: ;
                endcase
            end
        end
    end

endmodule
